// File: rtl/alu_operand_regfile.sv
// Register file plus registered operand stage feeding the 32-bit ALU.
// Two identical read ports (A from rs_addr, B from rt_addr) each with same-cycle write bypass.

module alu_operand_read_port #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wrEn,
    input  logic [ADDR_WIDTH-1:0] wrAddr,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic [DATA_WIDTH-1:0] memWord,
    output logic [DATA_WIDTH-1:0] rdData
);
    // Register 0 wins over the bypass so a discarded write never leaks through.
    always_comb begin
        rdData = memWord;
        if (addr == '0)
            rdData = '0;
        else if (wrEn && wrAddr == addr)
            rdData = wrData;
    end
endmodule

module alu_operand_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic [ADDR_WIDTH-1:0] rt_addr,
    input  logic                  rd_en,
    input  logic                  hold,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic                  operands_valid
);
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int NUM_PORTS = 2;

    // Entry 0 is never stored; the read ports force it to zero.
    logic [DEPTH-1:1][DATA_WIDTH-1:0] mem;

    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] rdAddr;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] memWord;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdData;

    assign rdAddr = {rt_addr, rs_addr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem <= '0;
        else if (wr_en && wr_addr != '0)
            mem[wr_addr] <= wr_data;
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : gPort
        assign memWord[p] = (rdAddr[p] == '0) ? '0 : mem[rdAddr[p]];

        alu_operand_read_port #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) uPort (
            .addr   (rdAddr[p]),
            .wrEn   (wr_en),
            .wrAddr (wr_addr),
            .wrData (wr_data),
            .memWord(memWord[p]),
            .rdData (rdData[p])
        );
    end

    // Hold freezes the whole operand stage; rd_en=0 only drops the valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out          <= '0;
            b_out          <= '0;
            operands_valid <= 1'b0;
        end else if (!hold) begin
            operands_valid <= rd_en;
            if (rd_en) begin
                a_out <= rdData[0];
                b_out <= rdData[1];
            end
        end
    end
endmodule
